div_scheduler: RTL and testbench

DIV_SCHEDULER -- requirements
Module: div_scheduler

---
 rtl/div_scheduler_if.sv | 46 ++++
 rtl/div_scheduler.sv | 161 ++++++++++++++++
 tb/tb_div_scheduler.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_scheduler_if.sv
// Request/response/divider bundle for div_scheduler: two request ports, one response port,
// and the control/data link to an external unsigned iterative divider.
interface div_scheduler_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_signed;
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_signed;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_q;
    logic [31:0] rsp_r;
    logic        rsp_dz;
    logic        rsp_to;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_load;
    logic        div_ena;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        div_dne;

    modport master (
        input  req0_valid, req0_a, req0_b, req0_signed,
        input  req1_valid, req1_a, req1_b, req1_signed,
        input  rsp_ready, div_q, div_r, div_dne,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_to,
        output div_a, div_b, div_load, div_ena
    );

    modport slave (
        output req0_valid, req0_a, req0_b, req0_signed,
        output req1_valid, req1_a, req1_b, req1_signed,
        output rsp_ready, div_q, div_r, div_dne,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dz, rsp_to,
        input  div_a, div_b, div_load, div_ena
    );
endinterface

// File: rtl/div_scheduler.sv
// Two-port round-robin front end for an external unsigned iterative divider: handles sign
// fix-up, divide-by-zero short cut and a watchdog on the divider's done strobe.
module div_scheduler #(
    parameter int unsigned MAX_CYCLES = 40
) (
    input  logic            clk,
    input  logic            rst,
    div_scheduler_if.master io_bus
);
    localparam int unsigned CntW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StFix, StResp} state_e;

    state_e          r_state;
    logic            r_ptr;
    logic [CntW-1:0] r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [31:0]     r_q_mag;
    logic [31:0]     r_r_mag;
    logic            r_rsp_valid;
    logic            r_rsp_id;
    logic [31:0]     r_rsp_q;
    logic [31:0]     r_rsp_r;
    logic            r_rsp_dz;
    logic            r_rsp_to;
    logic [31:0]     r_div_a;
    logic [31:0]     r_div_b;
    logic            r_div_load;
    logic            r_div_ena;

    logic            w_grant;
    logic            w_idle;
    logic            w_ready0;
    logic            w_ready1;
    logic            w_accept;
    logic [31:0]     w_a;
    logic [31:0]     w_b;
    logic            w_sgn;
    logic [31:0]     w_abs_a;
    logic [31:0]     w_abs_b;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        w_grant = r_ptr;
        if (io_bus.req0_valid && !io_bus.req1_valid) begin
            w_grant = 1'b0;
        end else if (!io_bus.req0_valid && io_bus.req1_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_idle   = !rst && (r_state == StIdle);
    assign w_ready0 = w_idle && io_bus.req0_valid && !w_grant;
    assign w_ready1 = w_idle && io_bus.req1_valid && w_grant;
    assign w_accept = w_ready0 || w_ready1;

    assign w_a   = w_grant ? io_bus.req1_a : io_bus.req0_a;
    assign w_b   = w_grant ? io_bus.req1_b : io_bus.req0_b;
    assign w_sgn = w_grant ? io_bus.req1_signed : io_bus.req0_signed;

    // 0x80000000 negates to itself, which is the correct unsigned magnitude.
    assign w_abs_a = (w_sgn && w_a[31]) ? (~w_a + 32'd1) : w_a;
    assign w_abs_b = (w_sgn && w_b[31]) ? (~w_b + 32'd1) : w_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_ptr       <= 1'b0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_q_mag     <= '0;
            r_r_mag     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_q     <= '0;
            r_rsp_r     <= '0;
            r_rsp_dz    <= 1'b0;
            r_rsp_to    <= 1'b0;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_div_load  <= 1'b0;
            r_div_ena   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_ptr    <= ~w_grant;
                        r_rsp_id <= w_grant;
                        r_rsp_dz <= 1'b0;
                        r_rsp_to <= 1'b0;
                        r_neg_q  <= w_sgn && (w_a[31] ^ w_b[31]);
                        r_neg_r  <= w_sgn && w_a[31];
                        if (w_b == '0) begin
                            r_rsp_q     <= '1;
                            r_rsp_r     <= w_a;
                            r_rsp_dz    <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= StResp;
                        end else begin
                            r_div_a    <= w_abs_a;
                            r_div_b    <= w_abs_b;
                            r_div_load <= 1'b1;
                            r_div_ena  <= 1'b1;
                            r_state    <= StLoad;
                        end
                    end
                end
                StLoad: begin
                    r_div_load <= 1'b0;
                    r_cnt      <= '0;
                    r_state    <= StRun;
                end
                StRun: begin
                    if (io_bus.div_dne) begin
                        r_q_mag   <= io_bus.div_q;
                        r_r_mag   <= io_bus.div_r;
                        r_div_ena <= 1'b0;
                        r_state   <= StFix;
                    end else if (r_cnt == CntW'(MAX_CYCLES - 1)) begin
                        r_div_ena   <= 1'b0;
                        r_rsp_q     <= '0;
                        r_rsp_r     <= '0;
                        r_rsp_to    <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                StFix: begin
                    r_rsp_q     <= r_neg_q ? (~r_q_mag + 32'd1) : r_q_mag;
                    r_rsp_r     <= r_neg_r ? (~r_r_mag + 32'd1) : r_r_mag;
                    r_rsp_valid <= 1'b1;
                    r_state     <= StResp;
                end
                StResp: begin
                    if (io_bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.req0_ready = w_ready0;
    assign io_bus.req1_ready = w_ready1;
    assign io_bus.rsp_valid  = r_rsp_valid;
    assign io_bus.rsp_id     = r_rsp_id;
    assign io_bus.rsp_q      = r_rsp_q;
    assign io_bus.rsp_r      = r_rsp_r;
    assign io_bus.rsp_dz     = r_rsp_dz;
    assign io_bus.rsp_to     = r_rsp_to;
    assign io_bus.div_a      = r_div_a;
    assign io_bus.div_b      = r_div_b;
    assign io_bus.div_load   = r_div_load;
    assign io_bus.div_ena    = r_div_ena;
endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: per-port request queues, a divider stub with per-operation latency,
// and a reference model that predicts grants, results, flags and latency into a scoreboard.
module tb_div_scheduler;
    localparam int unsigned MaxCycles = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_scheduler_if bus ();

    div_scheduler #(.MAX_CYCLES(MaxCycles)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus.master)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
        int          lat;
        bit          hang;
    } op_t;

    typedef struct {
        logic        id;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        to;
        int          lat;
        int          loads;
    } exp_t;

    op_t  pend0[$];
    op_t  pend1[$];
    exp_t sb[$];

    int n_cmp = 0;
    int n_err = 0;

    bit m_busy = 0;
    bit m_ptr = 0;
    bit m_seen = 0;
    bit rst_seen = 0;
    int m_lat_cnt = 0;
    int m_loads = 0;
    bit acc0 = 0;
    bit acc1 = 0;
    int cur_lat = 0;
    bit cur_hang = 0;
    int hold_low = 0;

    // Divider stub: results appear cur_lat enabled cycles after the load strobe.
    int          s_cnt = 0;
    logic [31:0] s_q = '0;
    logic [31:0] s_r = '0;
    always @(posedge clk) begin
        if (bus.div_load) begin
            s_cnt <= cur_lat;
            s_q   <= bus.div_a / bus.div_b;
            s_r   <= bus.div_a % bus.div_b;
        end else if (bus.div_ena && s_cnt > 0) begin
            s_cnt <= s_cnt - 1;
        end
    end
    assign bus.div_dne = bus.div_ena && !bus.div_load && (s_cnt == 0) && !cur_hang;
    assign bus.div_q   = s_q;
    assign bus.div_r   = s_r;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                               input int lat, input bit hang);
        op_t o;
        o.a = a; o.b = b; o.sgn = sgn; o.lat = lat; o.hang = hang;
        return o;
    endfunction

    // Truncating division on sign-extended 64-bit values; results taken modulo 2^32.
    function automatic exp_t model(input op_t o, input logic id);
        exp_t   e;
        longint sa, sbv, qq, rr;
        e.id = id; e.dz = 0; e.to = 0;
        if (o.b == 0) begin
            e.q = '1; e.r = o.a; e.dz = 1; e.lat = 1; e.loads = 0;
        end else if (o.hang) begin
            e.q = '0; e.r = '0; e.to = 1; e.lat = MaxCycles + 2; e.loads = 1;
        end else begin
            // states before RESP: LOAD, lat+1 RUN cycles, FIX
            e.lat = o.lat + 4; e.loads = 1;
            if (o.sgn) begin
                sa  = $signed(o.a);
                sbv = $signed(o.b);
                qq  = sa / sbv;
                rr  = sa - qq * sbv;
                e.q = qq[31:0];
                e.r = rr[31:0];
            end else begin
                e.q = o.a / o.b;
                e.r = o.a % o.b;
            end
        end
        return e;
    endfunction

    always @(negedge clk) begin
        bit   was_busy, v0, v1, g, er0, er1;
        exp_t e;
        op_t  o;
        if (rst) begin
            chk("ready_during_rst", {bus.req0_ready, bus.req1_ready}, 64'd0);
            sb.delete();
            m_busy = 0; m_ptr = 0; m_seen = 0; acc0 = 0; acc1 = 0;
            rst_seen = 1;
        end else begin
            if (rst_seen) begin
                rst_seen = 0;
                chk("rst_ctl", {bus.rsp_valid, bus.rsp_id, bus.rsp_dz, bus.rsp_to,
                                bus.div_load, bus.div_ena}, 64'd0);
                chk("rst_rsp", {bus.rsp_q, bus.rsp_r}, 64'd0);
                chk("rst_div", {bus.div_a, bus.div_b}, 64'd0);
            end
            was_busy = m_busy;
            if (m_busy && !m_seen) begin
                m_lat_cnt++;
                if (bus.div_load) m_loads++;
            end
            if (bus.rsp_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_rsp: got rsp_valid=1, required no response");
                end else begin
                    e = sb[0];
                    if (!m_seen) begin
                        m_seen = 1;
                        chk("latency", 64'(m_lat_cnt), 64'(e.lat));
                        chk("div_load_cycles", 64'(m_loads), 64'(e.loads));
                    end
                    chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
                    chk("rsp_q", 64'(bus.rsp_q), 64'(e.q));
                    chk("rsp_r", 64'(bus.rsp_r), 64'(e.r));
                    chk("rsp_flags", {bus.rsp_dz, bus.rsp_to}, {e.dz, e.to});
                    chk("div_idle_in_resp", {bus.div_load, bus.div_ena}, 64'd0);
                    if (bus.rsp_ready) begin
                        void'(sb.pop_front());
                        m_busy = 0;
                    end
                end
            end
            v0  = bus.req0_valid;
            v1  = bus.req1_valid;
            g   = (v0 && v1) ? m_ptr : v1;
            er0 = !was_busy && v0 && !g;
            er1 = !was_busy && v1 && g;
            chk("req0_ready", 64'(bus.req0_ready), 64'(er0));
            chk("req1_ready", 64'(bus.req1_ready), 64'(er1));
            if (er0 || er1) begin
                o = g ? pend1[0] : pend0[0];
                sb.push_back(model(o, g));
                m_ptr = !g; m_busy = 1; m_seen = 0; m_lat_cnt = 0; m_loads = 0;
                cur_lat = o.lat; cur_hang = o.hang;
                if (g) acc1 = 1; else acc0 = 1;
            end
        end
    end

    task automatic drive();
        bus.req0_valid  = pend0.size() > 0;
        bus.req0_a      = bus.req0_valid ? pend0[0].a : '0;
        bus.req0_b      = bus.req0_valid ? pend0[0].b : '0;
        bus.req0_signed = bus.req0_valid ? pend0[0].sgn : 1'b0;
        bus.req1_valid  = pend1.size() > 0;
        bus.req1_a      = bus.req1_valid ? pend1[0].a : '0;
        bus.req1_b      = bus.req1_valid ? pend1[0].b : '0;
        bus.req1_signed = bus.req1_valid ? pend1[0].sgn : 1'b0;
        if (hold_low > 0) begin
            bus.rsp_ready = 1'b0;
            hold_low--;
        end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (acc0) begin void'(pend0.pop_front()); acc0 = 0; end
        if (acc1) begin void'(pend1.pop_front()); acc1 = 0; end
        drive();
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (pend0.size() == 0 && pend1.size() == 0 && sb.size() == 0 && !m_busy) done = 1;
            else tick();
        end
        if (!done) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: got %0d responses outstanding, required 0", sb.size());
        end
    endtask

    initial begin
        logic [31:0] ra, rb;
        bit          found;
        bus.rsp_ready = 1'b0;
        // Both ports already requesting while reset is held.
        pend0.push_back(mk(32'd100, 32'd7, 1'b0, 5, 0));
        pend1.push_back(mk(32'hFFFF_FFF9, 32'd2, 1'b1, 3, 0));
        pend1.push_back(mk(32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0));
        pend0.push_back(mk(32'd5, 32'd0, 1'b0, 0, 0));
        pend0.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2, 0));
        pend1.push_back(mk(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1, 0));
        drive();
        repeat (3) tick();
        rst = 1'b0;
        drain(2000);

        pend1.push_back(mk(32'd1000, 32'd3, 1'b0, 2, 0));
        hold_low = 18;
        drain(500);

        pend0.push_back(mk(32'd9, 32'd4, 1'b0, 0, 1));
        drain(500);

        // Reset while the divider is running: the operation is dropped silently.
        pend0.push_back(mk(32'd50, 32'd5, 1'b0, 30, 0));
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (bus.div_ena && !bus.div_load) found = 1;
        end
        chk("reached_run", 64'(found), 64'd1);
        rst = 1'b1;
        pend0.delete();
        pend1.delete();
        drive();
        tick();
        rst = 1'b0;
        pend1.push_back(mk(32'hFFFF_FF9C, 32'd9, 1'b1, 4, 0));
        drain(500);

        for (int i = 0; i < 60; i++) begin
            ra = $urandom();
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom() >> $urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 1) == 0) pend0.push_back(mk(ra, rb, 1'($urandom()), $urandom_range(0, 20), 0));
            else pend1.push_back(mk(ra, rb, 1'($urandom()), $urandom_range(0, 20), 0));
        end
        drive();
        drain(6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
